// File: rtl/cut_sweep_signature.sv
// rtl/cut_sweep_signature.sv - exhaustive CUT input sweep with MISR response compaction
// Drives x through 0..2^N_IN-1, folds each captured f into a Galois MISR, hands the result out over valid/ready.
module cut_sweep_signature #(
   parameter int                N_IN   = 5,
   parameter int                N_OUT  = 12,
   parameter int                SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
   parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF,
   parameter int                SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic [N_IN-1:0]    x,
   input  logic [N_OUT-1:0]   f,
   output logic [SIG_W-1:0]   sig,
   output logic [N_IN:0]      vec_cnt,
   output logic               sig_valid,
   input  logic               sig_ready
);

   localparam bit         HAS_SETTLE    = (SETTLE > 0);
   localparam int         SETTLE_LOAD_I = HAS_SETTLE ? SETTLE - 1 : 0;
   localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE_LOAD_I);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_REPORT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        settle_cnt;
   logic [SIG_W-1:0]  misr;
   logic [SIG_W-1:0]  misr_nxt;
   logic              x_last;

   assign x_last = &x;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      misr_nxt  = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ SIG_W'(f);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = HAS_SETTLE ? ST_SETTLE : ST_CAPTURE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (settle_cnt == 4'd0) begin
               state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (x_last) begin
               state_nxt = ST_REPORT;
            end else begin
               state_nxt = HAS_SETTLE ? ST_SETTLE : ST_CAPTURE;
            end
         end
         ST_REPORT: begin
            if (abort || sig_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Abort leaves sig and vec_cnt untouched so the partial count stays observable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x          <= '0;
         busy       <= 1'b0;
         sig        <= '0;
         vec_cnt    <= '0;
         sig_valid  <= 1'b0;
         misr       <= SEED;
         settle_cnt <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x          <= '0;
                  misr       <= SEED;
                  vec_cnt    <= '0;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  x    <= '0;
                  busy <= 1'b0;
               end else if (settle_cnt != 4'd0) begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            ST_CAPTURE: begin
               if (abort) begin
                  x    <= '0;
                  busy <= 1'b0;
               end else begin
                  misr    <= misr_nxt;
                  vec_cnt <= vec_cnt + 1'b1;
                  if (x_last) begin
                     sig       <= misr_nxt;
                     sig_valid <= 1'b1;
                  end else begin
                     x          <= x + 1'b1;
                     settle_cnt <= SETTLE_LOAD;
                  end
               end
            end
            ST_REPORT: begin
               if (abort || sig_ready) begin
                  sig_valid <= 1'b0;
                  busy      <= 1'b0;
                  if (abort) begin
                     x <= '0;
                  end
               end
            end
            default: begin
               busy      <= 1'b0;
               sig_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/cut_sweep_signature.md
Name: cut_sweep_signature

Overview:
- Exhaustive stimulus and response-compaction stage wrapped around one combinational benchmark circuit under test (CUT) with N_IN inputs and N_OUT outputs.
- Drives every input vector 0..2^N_IN-1 onto the CUT inputs and captures the CUT outputs for each vector.
- Folds the captured outputs into a MISR signature.
- Hands the signature downstream over a valid/ready handshake, so circuit variants such as RESYN2 and original netlists can be checked for equivalence by signature compare.

Parameters:
- N_IN, 5, CUT input count; the sweep length is 2^N_IN vectors.
- N_OUT, 12, CUT output count; must be <= SIG_W.
- SIG_W, 16, MISR and signature width.
- POLY, 16'h1021, MISR feedback polynomial, Galois form.
- SEED, 16'hFFFF, MISR value loaded at sweep start.
- SETTLE, 1, idle cycles between driving a vector and capturing its response; range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  synchronous cancel of the sweep in progress.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- x  out  N_IN  registered vector driven to the CUT inputs.
- f  in  N_OUT  CUT outputs, combinational from x.
- sig  out  SIG_W  final signature; stable while sig_valid is high.
- vec_cnt  out  N_IN+1  number of vectors captured in the current or last sweep.
- sig_valid  out  1  signature available.
- sig_ready  in  1  downstream accepts the signature.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; x=0; busy=0; sig=0; vec_cnt=0; sig_valid=0; misr=SEED; settle counter=0.
  - Reset mid-sweep or mid-REPORT discards everything; no sig_valid is produced.
- States: IDLE, SETTLE, CAPTURE, REPORT.
- IDLE:
  - start=1 loads x=0, misr=SEED, vec_cnt=0, busy=1.
  - Next state is SETTLE if SETTLE>0, otherwise CAPTURE.
- SETTLE:
  - Holds x for exactly SETTLE cycles, counted by a down-counter loaded with SETTLE-1.
  - Moves to CAPTURE after the final count.
- CAPTURE: lasts one cycle and samples f.
  - misr <= {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ zero-extended f.
  - vec_cnt increments by 1.
  - If x == 2^N_IN-1: sig <= new misr value, sig_valid=1, go to REPORT. x stays at its final value.
  - Otherwise: x increments by 1, go to SETTLE, or stay in CAPTURE when SETTLE=0.
- Sweep length: exactly 2^N_IN*(SETTLE+1) cycles from the cycle after start up to and including the last CAPTURE. x never wraps within a sweep.
- REPORT:
  - sig_valid and sig are held until a cycle with sig_ready=1.
  - In that cycle the transfer completes. On the next edge: sig_valid=0, busy=0, state=IDLE.
  - sig and vec_cnt keep their values until the next accepted start.
  - sig_ready is ignored outside REPORT.
- start while busy is ignored. A start in the same cycle as the REPORT handshake is also ignored.
- abort=1 in SETTLE, CAPTURE or REPORT:
  - Next edge: IDLE, busy=0, sig_valid=0, x=0.
  - sig is unchanged; vec_cnt freezes at its current value.
  - abort in IDLE has no effect. abort has priority over the capture and handshake of the same cycle.
- rst_n has priority over abort, and abort has priority over start.

Test Plan:
- SEED=0, SETTLE=1, f tied to 0: pulse start → x steps 0..31, each value held 2 cycles; sig_valid rises 64 cycles after start; sig=16'h0000; vec_cnt=32.
- SEED=0, SETTLE=0, f=12'h001 only when x==31: sig=16'h0001, sig_valid rises 32 cycles after start. f=12'h005 only when x==30: sig=16'h000A.
- Default SEED/POLY, f driven by a reference model of the benchmark CUT: the signature matches the golden model computed in the bench. A single forced bit flip in f3 at x=7 yields a different sig.
- Hold sig_ready=0 for 10 cycles in REPORT: sig_valid and sig stay stable, busy=1. Raise sig_ready for 1 cycle → sig_valid=0 and busy=0 on the next edge.
- abort asserted at the 5th CAPTURE → IDLE, busy=0, no sig_valid, vec_cnt=4. A fresh start then produces the full 32-vector result.
- rst_n=0 mid-sweep at x=17 → all outputs return to reset values at the next edge. start pulses while busy=1 never restart or lengthen the sweep.
